gups_engine: RTL and testbench
==============================

Name: gups_engine

Overview:
- Parametrised random-access update engine. It is the next generation of the single-lane 64-bit `sys` updater.
- Each update generates a pseudo-random address, reads the word there, modifies it, and writes it back over the existing req/wr/rdy memory handshake.
- Adds over the previous block:
  - configurable data/address width and LFSR lane count;
  - three update modes;
  - a programmable update count with start/done control;
  - a completed-update counter.

Parameters:
- DW, 64: data width of din/dout and operand.
- AW, 64: address width of addr and range.
- NLANES, 4: number of 16-bit LFSR lanes concatenated into the random word.
- CW, 32: width of count and updates.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; accepted only in IDLE or DONE.
- mode  input  2  0 = increment, 1 = XOR with the random word, 2 = add operand, 3 = reserved (behaves as 0).
- count  input  CW  number of updates to perform; sampled on start.
- range  input  AW  address mask; sampled on start.
- operand  input  DW  addend for mode 2; sampled on start.
- seed  input  16*NLANES  lane seeds, lane 0 in bits [15:0]; sampled on start.
- addr  output  AW  memory address.
- din  input  DW  read data; valid in the cycle rdy=1 during a read.
- dout  output  DW  write data.
- req  output  1  memory request.
- wr  output  1  1 = write, 0 = read; valid while req=1.
- rdy  input  1  one-cycle memory completion strobe.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.
- updates  output  CW  updates completed since the last start.

Behaviour:
- Reset values: all outputs 0, state IDLE, LFSR lanes 0. Reset mid-operation aborts the transaction at that edge: req drops the next cycle and no write completes.
- LFSR lanes:
  - Each lane is a 16-bit Galois LFSR, right shift, tap mask 0xB400. Step: if lsb=1, lane=(lane>>1)^0xB400, else lane=lane>>1.
  - A zero seed loads as 0x0001.
  - All lanes step exactly once per update, in GEN.
- Random word: {lane[NLANES-1],...,lane[0]}, zero-extended or truncated to AW (for addr) and DW (for XOR). Address = post-step random word AND range.
- States and transitions:
  - IDLE: start → LOAD.
  - DONE: done=1; start → LOAD. All other inputs are ignored.
  - LOAD: latch count/range/operand/mode/seeds; clear updates. If count==0 → DONE, else → GEN.
  - GEN: step LFSRs, register addr → RD.
  - RD: req=1, wr=0, addr stable. On rdy=1, latch din → MOD.
  - MOD: compute the new word → WR.
    - mode 0: din+1.
    - mode 1: din^random.
    - mode 2: din+operand.
    - All arithmetic is modulo 2^DW; overflow wraps silently.
  - WR: req=1, wr=1, addr and dout stable. On rdy=1: updates+1; if updates+1==count → DONE, else → GEN.
- Handshake:
  - req, wr, addr and dout are held stable until the cycle rdy=1.
  - req deasserts the cycle after rdy.
  - A wait of 0..N cycles before rdy is legal.
  - rdy outside RD/WR is ignored.
- Latency:
  - start to first req (read) is 3 cycles: LOAD, GEN, RD.
  - With rdy returned in the first cycle of every request, one update takes 4 cycles (GEN, RD, MOD, WR).
- start while busy is ignored. start in the same cycle as rst: rst wins.
- Back-to-back updates that hit the same address are serialised: each read follows the previous write's rdy, so there is no hazard.
- updates saturates at count; it never wraps within a run.

Test Plan:
- Seeds all 0x0000 (load as 0x0001), NLANES=4, range=0x1FFF, mode 0, count=1, rdy after 0 cycles:
  - first addr = 0x1400 (random 0xB400B400B400B400 masked);
  - then a read, then a write of din+1;
  - done=1 and updates=1 after the write rdy.
- count=0, start pulse → done=1 two cycles after start; req never asserts; updates=0.
- Increment run: 8192-word model memory, random seeds, range=0x1FFF, mode 0, count=100, random rdy delay 0..5 cycles.
  - Every write equals the model's prior value plus 1.
  - Final memory matches the model.
  - updates=100.
- mode 1, all seeds 0x0001, din returned 0xFFFF_FFFF_FFFF_FFFF → dout = 0x4BFF4BFF4BFF4BFF.
- mode 2, operand=0x10, din=0xFFFF_FFFF_FFFF_FFF8 → dout = 0x0000_0000_0000_0008 (wrap).
- Robustness during a run:
  - rst asserted while in WR before rdy → req=0, busy=0, done=0, updates=0 the next cycle; no further requests until start.
  - Spurious rdy pulses while in IDLE are ignored.

Source files
------------

// File: rtl/gups_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : gups_engine_if
//  Purpose  : Memory request/response bus between the update engine and RAM.
//  Revision : 1.0 - initial release
// ============================================================================
interface gups_engine_if #(
    parameter int DW = 64,
    parameter int AW = 64
);
    logic          req;
    logic          wr;
    logic          rdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    modport master (output req, output wr, output addr, output dout,
                    input  din, input rdy);
    modport slave  (input  req, input  wr, input  addr, input  dout,
                    output din, output rdy);
endinterface
`default_nettype wire

// File: rtl/gups_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gups_engine
//  Purpose  : LFSR-addressed read-modify-write update engine with run control.
//  Revision : 1.0 - initial release
// ============================================================================
module gups_engine #(
    parameter int DW     = 64,
    parameter int AW     = 64,
    parameter int NLANES = 4,
    parameter int CW     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CW-1:0]         count,
    input  logic [AW-1:0]         range,
    input  logic [DW-1:0]         operand,
    input  logic [16*NLANES-1:0]  seed,
    gups_engine_if.master         mem,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         updates
);

    localparam int RW = 16 * NLANES;

    localparam logic [15:0] c_taps = 16'hB400;

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_load = 3'd1;
    localparam logic [2:0] c_gen  = 3'd2;
    localparam logic [2:0] c_rd   = 3'd3;
    localparam logic [2:0] c_mod  = 3'd4;
    localparam logic [2:0] c_wr   = 3'd5;
    localparam logic [2:0] c_done = 3'd6;

    logic [2:0]                 r_state;
    logic [2:0]                 w_next_state;
    logic [CW-1:0]              r_count;
    logic [CW-1:0]              r_updates;
    logic [CW-1:0]              w_upd_inc;
    logic [AW-1:0]              r_range;
    logic [AW-1:0]              r_addr;
    logic [DW-1:0]              r_operand;
    logic [DW-1:0]              r_din;
    logic [DW-1:0]              r_dout;
    logic [DW-1:0]              w_mod_result;
    logic [1:0]                 r_mode;
    logic [NLANES-1:0][15:0]    r_lane;
    logic [NLANES-1:0][15:0]    w_lane_step;
    logic [RW-1:0]              w_rand_now;
    logic [RW-1:0]              w_rand_next;
    logic [AW-1:0]              w_rand_a;
    logic [DW-1:0]              w_rand_d;
    logic                       w_accept;
    logic                       w_req;
    logic                       w_wr;

    assign w_accept    = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_upd_inc   = r_updates + CW'(1);
    assign w_rand_now  = r_lane;
    assign w_rand_next = w_lane_step;

    // Galois right-shift step for every lane in parallel
    always_comb begin
        w_lane_step = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_lane_step[i] = r_lane[i][0] ? ((r_lane[i] >> 1) ^ c_taps)
                                          : (r_lane[i] >> 1);
        end
    end

    generate
        if (AW > RW) begin : g_addr_zext
            assign w_rand_a = {{(AW-RW){1'b0}}, w_rand_next};
        end else begin : g_addr_fit
            assign w_rand_a = w_rand_next[AW-1:0];
        end
        if (DW > RW) begin : g_data_zext
            assign w_rand_d = {{(DW-RW){1'b0}}, w_rand_now};
        end else begin : g_data_fit
            assign w_rand_d = w_rand_now[DW-1:0];
        end
    endgenerate

    always_comb begin
        w_mod_result = r_din + DW'(1);
        case (r_mode)
            2'd1:    w_mod_result = r_din ^ w_rand_d;
            2'd2:    w_mod_result = r_din + r_operand;
            default: w_mod_result = r_din + DW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle, c_done: if (start) w_next_state = c_load;
            c_load:         w_next_state = (r_count == '0) ? c_done : c_gen;
            c_gen:          w_next_state = c_rd;
            c_rd:           if (mem.rdy) w_next_state = c_mod;
            c_mod:          w_next_state = c_wr;
            c_wr:           if (mem.rdy) w_next_state = (w_upd_inc == r_count) ? c_done : c_gen;
            default:        w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        w_wr  = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (r_state)
            c_idle: busy = 1'b0;
            c_done: begin
                busy = 1'b0;
                done = 1'b1;
            end
            c_rd:   w_req = 1'b1;
            c_wr: begin
                w_req = 1'b1;
                w_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    // Run configuration is captured on the accepting edge so LOAD sees it registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_range   <= '0;
            r_operand <= '0;
            r_mode    <= '0;
            r_updates <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_dout    <= '0;
            r_lane    <= '0;
        end else if (w_accept) begin
            r_count   <= count;
            r_range   <= range;
            r_operand <= operand;
            r_mode    <= mode;
            r_updates <= '0;
            for (int i = 0; i < NLANES; i++) begin
                r_lane[i] <= (seed[16*i +: 16] == 16'h0) ? 16'h0001 : seed[16*i +: 16];
            end
        end else begin
            case (r_state)
                c_gen: begin
                    r_lane <= w_lane_step;
                    r_addr <= w_rand_a & r_range;
                end
                c_rd:  if (mem.rdy) r_din <= mem.din;
                c_mod: r_dout <= w_mod_result;
                c_wr:  if (mem.rdy && (r_updates != r_count)) r_updates <= w_upd_inc;
                default: ;
            endcase
        end
    end

    assign mem.req  = w_req;
    assign mem.wr   = w_wr;
    assign mem.addr = r_addr;
    assign mem.dout = r_dout;
    assign updates  = r_updates;

endmodule
`default_nettype wire

// File: tb/tb_gups_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gups_engine
//  Purpose  : Scoreboard bench for gups_engine with a delay-randomised memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gups_engine;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NL = 4;
    localparam int CW = 32;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [CW-1:0]   count = '0;
    logic [AW-1:0]   cfg_range = '0;
    logic [DW-1:0]   operand = '0;
    logic [16*NL-1:0] seed = '0;
    logic            busy;
    logic            done;
    logic [CW-1:0]   updates;

    gups_engine_if #(.DW(DW), .AW(AW)) mem_if ();

    gups_engine #(.DW(DW), .AW(AW), .NLANES(NL), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .range   (cfg_range),
        .operand (operand),
        .seed    (seed),
        .mem     (mem_if),
        .busy    (busy),
        .done    (done),
        .updates (updates)
    );

    always #5 clk = ~clk;

    logic [63:0] tbmem    [8192];
    logic [63:0] modelmem [8192];
    exp_t        expq [$];
    int          total = 0;
    int          bad = 0;
    int          req_cycles = 0;
    int          max_delay = 0;
    bit          hold_en = 1'b0;
    int          writes_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Mode-0 reference: pushes n expected writes and updates the model memory
    task automatic predict(input logic [63:0] sd, input int n, input logic [63:0] rng);
        logic [15:0] ln [4];
        logic [63:0] a;
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            ln[i] = sd[16*i +: 16];
            if (ln[i] == 16'h0) ln[i] = 16'h0001;
        end
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++) ln[i] = lfsr_step(ln[i]);
            a = {ln[3], ln[2], ln[1], ln[0]} & rng;
            v = modelmem[a[12:0]] + 64'd1;
            modelmem[a[12:0]] = v;
            expq.push_back('{a: a, d: v});
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] c, input logic [63:0] rng,
                             input logic [63:0] op, input logic [63:0] sd);
        @(posedge clk); #1;
        mode = m; count = c; cfg_range = rng; operand = op; seed = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {63'd0, done}, 64'd1);
    endtask

    // Memory slave: random completion delay, optional write stall
    initial begin : responder
        bit active = 1'b0;
        int cnt = 0;
        mem_if.rdy = 1'b0;
        mem_if.din = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_if.rdy) begin
                mem_if.rdy = 1'b0;
            end else if (mem_if.req && !(mem_if.wr && hold_en && writes_left == 0)) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = $urandom_range(max_delay, 0);
                end
                if (cnt == 0) begin
                    active = 1'b0;
                    mem_if.rdy = 1'b1;
                    if (mem_if.wr) begin
                        tbmem[mem_if.addr[12:0]] = mem_if.dout;
                        if (hold_en) writes_left--;
                    end else begin
                        mem_if.din = tbmem[mem_if.addr[12:0]];
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_if.req) req_cycles++;
        if (mem_if.req && mem_if.wr && mem_if.rdy) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h", mem_if.addr, mem_if.dout);
            end else begin
                e = expq.pop_front();
                check("wr_addr", mem_if.addr, e.a);
                check("wr_data", mem_if.dout, e.d);
            end
        end
    end

    initial begin : stimulus
        logic [63:0] rs;
        int rc;
        int n;
        int errs;
        for (int i = 0; i < 8192; i++) tbmem[i] = 64'(i) * 64'h9E3779B97F4A7C15;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",     {63'd0, mem_if.req}, 64'd0);
        check("rst_wr",      {63'd0, mem_if.wr},  64'd0);
        check("rst_addr",    mem_if.addr, 64'd0);
        check("rst_dout",    mem_if.dout, 64'd0);
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_updates", 64'(updates), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single increment from zero seeds: first address 0x1400
        max_delay = 0;
        tbmem[13'h1400] = 64'h1234;
        expq.push_back('{a: 64'h1400, d: 64'h1235});
        start_run(2'd0, 32'd1, 64'h1FFF, 64'd0, 64'd0);
        @(negedge clk);
        check("load_req",  {63'd0, mem_if.req}, 64'd0);
        check("load_busy", {63'd0, busy}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("first_req",  {63'd0, mem_if.req}, 64'd1);
        check("first_rd",   {63'd0, mem_if.wr}, 64'd0);
        check("first_addr", mem_if.addr, 64'h1400);
        wait_done(50);
        check("t1_updates", 64'(updates), 64'd1);

        // count = 0 goes straight to DONE
        rc = req_cycles;
        start_run(2'd0, 32'd0, 64'h1FFF, 64'd0, 64'd0);
        @(negedge clk);
        check("cnt0_load_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("cnt0_done",    {63'd0, done}, 64'd1);
        check("cnt0_updates", 64'(updates), 64'd0);
        check("cnt0_noreq",   64'(req_cycles - rc), 64'd0);

        // XOR with random word
        tbmem[13'h1400] = 64'hFFFF_FFFF_FFFF_FFFF;
        expq.push_back('{a: 64'h1400, d: 64'h4BFF4BFF4BFF4BFF});
        start_run(2'd1, 32'd1, 64'h1FFF, 64'd0, 64'h0001_0001_0001_0001);
        wait_done(50);

        // Add operand with wrap
        tbmem[13'h1400] = 64'hFFFF_FFFF_FFFF_FFF8;
        expq.push_back('{a: 64'h1400, d: 64'h0000_0000_0000_0008});
        start_run(2'd2, 32'd1, 64'h1FFF, 64'h10, 64'd0);
        wait_done(50);

        // 100 increments with random seeds and random memory latency
        for (int i = 0; i < 8192; i++) modelmem[i] = tbmem[i];
        rs = {$urandom, $urandom};
        predict(rs, 100, 64'h1FFF);
        max_delay = 5;
        start_run(2'd0, 32'd100, 64'h1FFF, 64'd0, rs);
        wait_done(3000);
        check("run_updates", 64'(updates), 64'd100);
        check("run_queue",   64'(expq.size()), 64'd0);
        errs = 0;
        for (int i = 0; i < 8192; i++) if (tbmem[i] !== modelmem[i]) errs++;
        check("run_memory", 64'(errs), 64'd0);

        // Reset while the third write is stalled
        max_delay = 0;
        for (int i = 0; i < 8192; i++) modelmem[i] = tbmem[i];
        predict(64'd0, 2, 64'h1FFF);
        hold_en = 1'b1;
        writes_left = 2;
        start_run(2'd0, 32'd5, 64'h1FFF, 64'd0, 64'd0);
        n = 0;
        @(negedge clk);
        while (!(mem_if.req && mem_if.wr && updates == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", {63'd0, mem_if.req && mem_if.wr}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req",     {63'd0, mem_if.req}, 64'd0);
        check("abort_busy",    {63'd0, busy}, 64'd0);
        check("abort_done",    {63'd0, done}, 64'd0);
        check("abort_updates", 64'(updates), 64'd0);
        hold_en = 1'b0;
        rc = req_cycles;
        repeat (20) @(negedge clk);
        check("abort_noreq", 64'(req_cycles - rc), 64'd0);
        check("abort_queue", 64'(expq.size()), 64'd0);

        // Spurious rdy pulses while idle
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            mem_if.rdy = 1'b1;
            mem_if.din = 64'hDEAD_BEEF_0000_0000 | 64'(p);
            @(negedge clk);
            check("spur_busy", {63'd0, busy}, 64'd0);
            check("spur_req",  {63'd0, mem_if.req}, 64'd0);
        end
        check("spur_updates", 64'(updates), 64'd0);
        check("spur_done",    {63'd0, done}, 64'd0);

        tbmem[13'h1400] = 64'h77;
        expq.push_back('{a: 64'h1400, d: 64'h78});
        start_run(2'd0, 32'd1, 64'h1FFF, 64'd0, 64'd0);
        wait_done(50);
        check("final_updates", 64'(updates), 64'd1);
        check("final_queue",   64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
